// File: rtl/mips_ctrl_pkg.sv
// Shared types for the multi-cycle MIPS control unit: FSM states, opcode,
// funct and REGIMM rt codes, alu_op / pc_sel encodings and the static
// decode record produced by mips_decode.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_EXEC   = 3'd1,
        ST_MEM    = 3'd2,
        ST_MULDIV = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    // Instruction class, drives the EXEC/MEM/MULDIV sequencing
    typedef enum logic [3:0] {
        IC_NOP    = 4'd0,
        IC_ALU    = 4'd1,
        IC_LOAD   = 4'd2,
        IC_STORE  = 4'd3,
        IC_MULDIV = 4'd4,
        IC_MTHI   = 4'd5,
        IC_MTLO   = 4'd6,
        IC_BRANCH = 4'd7,
        IC_JUMP   = 4'd8
    } iclass_t;

    // Opcodes
    localparam logic [5:0] OP_SPECIAL = 6'd0;
    localparam logic [5:0] OP_REGIMM  = 6'd1;
    localparam logic [5:0] OP_J       = 6'd2;
    localparam logic [5:0] OP_JAL     = 6'd3;
    localparam logic [5:0] OP_BEQ     = 6'd4;
    localparam logic [5:0] OP_BNE     = 6'd5;
    localparam logic [5:0] OP_BLEZ    = 6'd6;
    localparam logic [5:0] OP_BGTZ    = 6'd7;
    localparam logic [5:0] OP_ADDI    = 6'd8;
    localparam logic [5:0] OP_ADDIU   = 6'd9;
    localparam logic [5:0] OP_SLTI    = 6'd10;
    localparam logic [5:0] OP_SLTIU   = 6'd11;
    localparam logic [5:0] OP_ANDI    = 6'd12;
    localparam logic [5:0] OP_ORI     = 6'd13;
    localparam logic [5:0] OP_XORI    = 6'd14;
    localparam logic [5:0] OP_LUI     = 6'd15;
    localparam logic [5:0] OP_LB      = 6'd32;
    localparam logic [5:0] OP_LH      = 6'd33;
    localparam logic [5:0] OP_LW      = 6'd35;
    localparam logic [5:0] OP_LBU     = 6'd36;
    localparam logic [5:0] OP_LHU     = 6'd37;
    localparam logic [5:0] OP_SB      = 6'd40;
    localparam logic [5:0] OP_SH      = 6'd41;
    localparam logic [5:0] OP_SW      = 6'd43;

    // SPECIAL funct codes
    localparam logic [5:0] F_SLL   = 6'd0;
    localparam logic [5:0] F_SRL   = 6'd2;
    localparam logic [5:0] F_SRA   = 6'd3;
    localparam logic [5:0] F_SLLV  = 6'd4;
    localparam logic [5:0] F_SRLV  = 6'd6;
    localparam logic [5:0] F_SRAV  = 6'd7;
    localparam logic [5:0] F_JR    = 6'd8;
    localparam logic [5:0] F_JALR  = 6'd9;
    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MTHI  = 6'd17;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MTLO  = 6'd19;
    localparam logic [5:0] F_MULT  = 6'd24;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIV   = 6'd26;
    localparam logic [5:0] F_DIVU  = 6'd27;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_ADDU  = 6'd33;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_SUBU  = 6'd35;
    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_XOR   = 6'd38;
    localparam logic [5:0] F_NOR   = 6'd39;
    localparam logic [5:0] F_SLT   = 6'd42;
    localparam logic [5:0] F_SLTU  = 6'd43;

    // REGIMM rt (b_code) values
    localparam logic [4:0] B_BLTZ   = 5'd0;
    localparam logic [4:0] B_BGEZ   = 5'd1;
    localparam logic [4:0] B_BLTZAL = 5'd16;
    localparam logic [4:0] B_BGEZAL = 5'd17;

    // alu_op encodings
    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;
    localparam logic [1:0] ALU_LOGIC = 2'd3;

    // pc_sel encodings
    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_REG    = 2'd3;

    typedef struct packed {
        iclass_t    iclass;
        logic       link;       // writes PC+8 in EXEC
        logic [1:0] target_sel; // pc_sel to defer into the delay slot
        logic       rd_select;
        logic       link_sel;
        logic       imdt_sel;
        logic [1:0] alu_op;
        logic       alu_src;
    } ctrl_t;

    // Decode record for an unknown / no-op instruction
    function automatic ctrl_t ctrl_nop();
        ctrl_t c;
        c.iclass     = IC_NOP;
        c.link       = 1'b0;
        c.target_sel = PC_SEQ;
        c.rd_select  = 1'b0;
        c.link_sel   = 1'b0;
        c.imdt_sel   = 1'b0;
        c.alu_op     = ALU_ADD;
        c.alu_src    = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/mips_decode.sv
// Purely combinational instruction decoder.
// Ports:
//   opcode_i  IR[31:26]
//   rt_i      IR[20:16] (REGIMM branch code)
//   funct_i   IR[5:0]
//   ctrl_o    static decode fields and instruction class
module mips_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [4:0] rt_i,
    input  logic [5:0] funct_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = ctrl_nop();
        case (opcode_i)
            OP_SPECIAL: begin
                ctrl_o.rd_select = 1'b1;
                ctrl_o.alu_op    = ALU_FUNCT;
                case (funct_i)
                    F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
                    F_MFHI, F_MFLO, F_ADD, F_ADDU, F_SUB, F_SUBU,
                    F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU:
                        ctrl_o.iclass = IC_ALU;
                    F_JR: begin
                        ctrl_o.iclass     = IC_JUMP;
                        ctrl_o.target_sel = PC_REG;
                    end
                    F_JALR: begin
                        ctrl_o.iclass     = IC_JUMP;
                        ctrl_o.target_sel = PC_REG;
                        ctrl_o.link       = 1'b1;
                        ctrl_o.link_sel   = 1'b1;
                    end
                    F_MTHI: ctrl_o.iclass = IC_MTHI;
                    F_MTLO: ctrl_o.iclass = IC_MTLO;
                    F_MULT, F_MULTU, F_DIV, F_DIVU:
                        ctrl_o.iclass = IC_MULDIV;
                    default: ctrl_o.iclass = IC_NOP;
                endcase
            end
            OP_REGIMM: begin
                ctrl_o.alu_op     = ALU_SUB;
                ctrl_o.target_sel = PC_BRANCH;
                case (rt_i)
                    B_BLTZ, B_BGEZ: ctrl_o.iclass = IC_BRANCH;
                    B_BLTZAL, B_BGEZAL: begin
                        ctrl_o.iclass   = IC_BRANCH;
                        ctrl_o.link     = 1'b1;
                        ctrl_o.link_sel = 1'b1;
                    end
                    default: ctrl_o.iclass = IC_NOP;
                endcase
            end
            OP_J: begin
                ctrl_o.iclass     = IC_JUMP;
                ctrl_o.target_sel = PC_JUMP;
            end
            OP_JAL: begin
                ctrl_o.iclass     = IC_JUMP;
                ctrl_o.target_sel = PC_JUMP;
                ctrl_o.link       = 1'b1;
                ctrl_o.link_sel   = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                ctrl_o.iclass     = IC_BRANCH;
                ctrl_o.alu_op     = ALU_SUB;
                ctrl_o.target_sel = PC_BRANCH;
            end
            OP_ADDI, OP_ADDIU: begin
                ctrl_o.iclass  = IC_ALU;
                ctrl_o.alu_src = 1'b1;
            end
            OP_SLTI, OP_SLTIU: begin
                ctrl_o.iclass  = IC_ALU;
                ctrl_o.alu_op  = ALU_SUB;
                ctrl_o.alu_src = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl_o.iclass   = IC_ALU;
                ctrl_o.alu_op   = ALU_LOGIC;
                ctrl_o.alu_src  = 1'b1;
                ctrl_o.imdt_sel = 1'b1;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                ctrl_o.iclass  = IC_LOAD;
                ctrl_o.alu_src = 1'b1;
            end
            OP_SB, OP_SH, OP_SW: begin
                ctrl_o.iclass  = IC_STORE;
                ctrl_o.alu_src = 1'b1;
            end
            default: ctrl_o = ctrl_nop();
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences FETCH -> EXEC -> (MEM | MULDIV)
// and issues datapath strobes, with branch delay slots, halt on a PC write
// of zero and a bus wait-limit fault.
// Optional build macro: MULDIV_FIXED_LATENCY_EN (MULDIV exits after exactly
// MULDIV_CYCLES cycles, muldiv_done ignored).
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   instr_word                    fetch read data (decode fields kept locally)
//   mem_waitrequest               bus stall for instruction/data requests
//   branch_cond, next_pc_zero     datapath status
//   muldiv_done                   multiply/divide result valid
//   active, bus_fault             run status (registered)
//   instr_read..lo_wren           strobes decoded from registered state
//   rd_select..alu_src, pc_sel    static decode from the IR / delay register
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MULDIV_CYCLES = 32,
    parameter int unsigned MEM_WAIT_MAX  = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instr_word,
    input  logic        mem_waitrequest,
    input  logic        branch_cond,
    input  logic        next_pc_zero,
    input  logic        muldiv_done,
    output logic        active,
    output logic        bus_fault,
    output logic        instr_read,
    output logic        data_read,
    output logic        data_write,
    output logic        ir_wren,
    output logic        pc_wren,
    output logic [1:0]  pc_sel,
    output logic        reg_write_enable,
    output logic        rd_select,
    output logic        link_sel,
    output logic        imdt_sel,
    output logic [1:0]  alu_op,
    output logic        alu_src,
    output logic        muldiv_start,
    output logic        hi_wren,
    output logic        lo_wren
);

    localparam logic [7:0] WAIT_LAST =
        (MEM_WAIT_MAX == 0) ? 8'd0 : 8'(MEM_WAIT_MAX - 1);

    state_t     state_q, state_d;
    logic       active_q, active_d;
    logic       bus_fault_q, bus_fault_d;
    logic       delay_valid_q, delay_valid_d;
    logic [1:0] delay_sel_q, delay_sel_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [5:0] opcode_q, funct_q;
    logic [4:0] rt_q;
    ctrl_t      ctrl;
    logic       set_delay;
    logic       wait_limit;
    logic       muldiv_exit;

    // Only the fields the decoder needs are kept; the datapath owns the full IR
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr_word[25:21], instr_word[15:6]};

    mips_decode u_decode (
        .opcode_i (opcode_q),
        .rt_i     (rt_q),
        .funct_i  (funct_q),
        .ctrl_o   (ctrl)
    );

    assign rd_select = ctrl.rd_select;
    assign link_sel  = ctrl.link_sel;
    assign imdt_sel  = ctrl.imdt_sel;
    assign alu_op    = ctrl.alu_op;
    assign alu_src   = ctrl.alu_src;
    assign active    = active_q;
    assign bus_fault = bus_fault_q;
    // A pending delay-slot target applies to the next PC write
    assign pc_sel    = delay_valid_q ? delay_sel_q : PC_SEQ;

`ifdef MULDIV_FIXED_LATENCY_EN
    localparam logic [7:0] MD_LAST = 8'(MULDIV_CYCLES - 1);
    logic [7:0] md_cnt_q, md_cnt_d;
    logic       unused_muldiv_done;

    assign unused_muldiv_done = muldiv_done;
    assign md_cnt_d    = (state_q == ST_MULDIV) ? md_cnt_q + 8'd1 : 8'd0;
    assign muldiv_exit = (state_q == ST_MULDIV) && (md_cnt_q == MD_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) md_cnt_q <= 8'd0;
        else          md_cnt_q <= md_cnt_d;
    end
`else
    // muldiv_done is registered; HI/LO are written the cycle after it
    logic       done_seen_q, done_seen_d;
    logic [7:0] unused_cfg;

    assign unused_cfg  = 8'(MULDIV_CYCLES);
    assign done_seen_d = (state_q == ST_MULDIV) && !done_seen_q && muldiv_done;
    assign muldiv_exit = (state_q == ST_MULDIV) && done_seen_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) done_seen_q <= 1'b0;
        else          done_seen_q <= done_seen_d;
    end
`endif

    // State and status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_FETCH;
            active_q      <= 1'b0;
            bus_fault_q   <= 1'b0;
            delay_valid_q <= 1'b0;
            delay_sel_q   <= PC_SEQ;
            wait_cnt_q    <= 8'd0;
        end else begin
            state_q       <= state_d;
            active_q      <= active_d;
            bus_fault_q   <= bus_fault_d;
            delay_valid_q <= delay_valid_d;
            delay_sel_q   <= delay_sel_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    // Local copy of the IR decode fields
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opcode_q <= 6'd0;
            rt_q     <= 5'd0;
            funct_q  <= 6'd0;
        end else if (ir_wren) begin
            opcode_q <= instr_word[31:26];
            rt_q     <= instr_word[20:16];
            funct_q  <= instr_word[5:0];
        end
    end

    // Next state and strobes
    always_comb begin
        state_d          = state_q;
        bus_fault_d      = bus_fault_q;
        delay_valid_d    = delay_valid_q;
        delay_sel_d      = delay_sel_q;
        wait_cnt_d       = 8'd0;
        instr_read       = 1'b0;
        ir_wren          = 1'b0;
        data_read        = 1'b0;
        data_write       = 1'b0;
        pc_wren          = 1'b0;
        reg_write_enable = 1'b0;
        muldiv_start     = 1'b0;
        hi_wren          = 1'b0;
        lo_wren          = 1'b0;
        set_delay        = 1'b0;
        wait_limit       = (MEM_WAIT_MAX != 0) && mem_waitrequest &&
                           (wait_cnt_q == WAIT_LAST);

        case (state_q)
            ST_FETCH: begin
                // active_q low: first cycle after reset release, no request yet
                if (active_q) begin
                    instr_read = 1'b1;
                    if (mem_waitrequest) begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                        if (wait_limit) begin
                            bus_fault_d = 1'b1;
                            state_d     = ST_HALTED;
                        end
                    end else begin
                        ir_wren = 1'b1;
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (ctrl.iclass)
                    IC_ALU: begin
                        reg_write_enable = 1'b1;
                        pc_wren          = 1'b1;
                    end
                    IC_LOAD, IC_STORE: state_d = ST_MEM;
                    IC_MULDIV: begin
                        muldiv_start = 1'b1;
                        state_d      = ST_MULDIV;
                    end
                    IC_MTHI: begin
                        hi_wren = 1'b1;
                        pc_wren = 1'b1;
                    end
                    IC_MTLO: begin
                        lo_wren = 1'b1;
                        pc_wren = 1'b1;
                    end
                    IC_BRANCH: begin
                        pc_wren          = 1'b1;
                        reg_write_enable = ctrl.link;
                        set_delay        = branch_cond;
                    end
                    IC_JUMP: begin
                        pc_wren          = 1'b1;
                        reg_write_enable = ctrl.link;
                        set_delay        = 1'b1;
                    end
                    default: pc_wren = 1'b1;
                endcase
            end
            ST_MEM: begin
                data_read  = (ctrl.iclass == IC_LOAD);
                data_write = (ctrl.iclass == IC_STORE);
                if (mem_waitrequest) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (wait_limit) begin
                        bus_fault_d = 1'b1;
                        state_d     = ST_HALTED;
                    end
                end else begin
                    reg_write_enable = (ctrl.iclass == IC_LOAD);
                    pc_wren          = 1'b1;
                    state_d          = ST_FETCH;
                end
            end
            ST_MULDIV: begin
                if (muldiv_exit) begin
                    hi_wren = 1'b1;
                    lo_wren = 1'b1;
                    pc_wren = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_HALTED;
        endcase

        // Every PC write consumes the pending target; a new one may replace it
        if (pc_wren) begin
            delay_valid_d = set_delay;
            delay_sel_d   = set_delay ? ctrl.target_sel : PC_SEQ;
            if (next_pc_zero) state_d = ST_HALTED;
        end

        active_d = (state_d != ST_HALTED);
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
module tb_mips_multicycle_control;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] instr_word;
    logic        mem_waitrequest;
    logic        branch_cond;
    logic        next_pc_zero;
    logic        muldiv_done;
    logic        active, bus_fault, instr_read, data_read, data_write;
    logic        ir_wren, pc_wren, reg_write_enable, rd_select, link_sel;
    logic        imdt_sel, alu_src, muldiv_start, hi_wren, lo_wren;
    logic [1:0]  pc_sel, alu_op;

    int total = 0;
    int bad   = 0;

    // Strobe vector: {instr_read, data_read, data_write, ir_wren, pc_wren,
    //                 reg_write_enable, muldiv_start, hi_wren, lo_wren}
    logic [8:0] strb;
    assign strb = {instr_read, data_read, data_write, ir_wren, pc_wren,
                   reg_write_enable, muldiv_start, hi_wren, lo_wren};

    localparam logic [8:0] S_NONE = 9'b0_0000_0000;
    localparam logic [8:0] S_IR   = 9'b1_0000_0000;
    localparam logic [8:0] S_DR   = 9'b0_1000_0000;
    localparam logic [8:0] S_DW   = 9'b0_0100_0000;
    localparam logic [8:0] S_IRW  = 9'b0_0010_0000;
    localparam logic [8:0] S_PCW  = 9'b0_0001_0000;
    localparam logic [8:0] S_RWE  = 9'b0_0000_1000;
    localparam logic [8:0] S_MDS  = 9'b0_0000_0100;
    localparam logic [8:0] S_HI   = 9'b0_0000_0010;
    localparam logic [8:0] S_LO   = 9'b0_0000_0001;

    localparam logic [31:0] I_ADDU = {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'd33};
    localparam logic [31:0] I_LW   = {6'd35, 5'd1, 5'd2, 16'h0004};
    localparam logic [31:0] I_SW   = {6'd43, 5'd1, 5'd2, 16'h0008};
    localparam logic [31:0] I_BEQ  = {6'd4, 5'd1, 5'd2, 16'h0003};
    localparam logic [31:0] I_MULT = {6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 6'd24};
    localparam logic [31:0] I_JR   = {6'd0, 5'd31, 5'd0, 5'd0, 5'd0, 6'd8};

    mips_multicycle_control #(
        .MULDIV_CYCLES (4),
        .MEM_WAIT_MAX  (255)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .instr_word       (instr_word),
        .mem_waitrequest  (mem_waitrequest),
        .branch_cond      (branch_cond),
        .next_pc_zero     (next_pc_zero),
        .muldiv_done      (muldiv_done),
        .active           (active),
        .bus_fault        (bus_fault),
        .instr_read       (instr_read),
        .data_read        (data_read),
        .data_write       (data_write),
        .ir_wren          (ir_wren),
        .pc_wren          (pc_wren),
        .pc_sel           (pc_sel),
        .reg_write_enable (reg_write_enable),
        .rd_select        (rd_select),
        .link_sel         (link_sel),
        .imdt_sel         (imdt_sel),
        .alu_op           (alu_op),
        .alu_src          (alu_src),
        .muldiv_start     (muldiv_start),
        .hi_wren          (hi_wren),
        .lo_wren          (lo_wren)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n         = 1'b0;
        instr_word      = 32'd0;
        mem_waitrequest = 1'b1;
        branch_cond     = 1'b0;
        next_pc_zero    = 1'b0;
        muldiv_done     = 1'b0;
        step();
        step();
        #1;
        chk("rst_strb", 32'(strb), 32'(S_NONE));
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_fault", 32'(bus_fault), 32'd0);
        chk("rst_pcsel", 32'(pc_sel), 32'd0);

        // Release: active rises only at the following edge
        reset_n = 1'b1;
        #1;
        chk("rel_active", 32'(active), 32'd0);
        chk("rel_strb", 32'(strb), 32'(S_NONE));
        step();
        #1;
        chk("run_active", 32'(active), 32'd1);
        chk("fetch_stall", 32'(strb), 32'(S_IR));

        // ADDU: fetch handshake then 1-cycle EXEC
        mem_waitrequest = 1'b0;
        instr_word      = I_ADDU;
        #1;
        chk("addu_fetch", 32'(strb), 32'(S_IR | S_IRW));
        step();
        #1;
        chk("addu_exec", 32'(strb), 32'(S_PCW | S_RWE));
        chk("addu_rdsel", 32'(rd_select), 32'd1);
        chk("addu_aluop", 32'(alu_op), 32'd2);
        chk("addu_alusrc", 32'(alu_src), 32'd0);
        chk("addu_pcsel", 32'(pc_sel), 32'd0);

        // LW with three stalled MEM cycles
        step();
        instr_word = I_LW;
        #1;
        chk("lw_fetch", 32'(strb), 32'(S_IR | S_IRW));
        step();
        mem_waitrequest = 1'b1;
        #1;
        chk("lw_exec", 32'(strb), 32'(S_NONE));
        chk("lw_rdsel", 32'(rd_select), 32'd0);
        chk("lw_imdt", 32'(imdt_sel), 32'd0);
        chk("lw_alusrc", 32'(alu_src), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            chk("lw_mem_wait", 32'(strb), 32'(S_DR));
        end
        step();
        mem_waitrequest = 1'b0;
        #1;
        chk("lw_mem_done", 32'(strb), 32'(S_DR | S_RWE | S_PCW));

        // BEQ taken, ADDU in its delay slot
        step();
        instr_word = I_BEQ;
        #1;
        chk("beq_fetch", 32'(strb), 32'(S_IR | S_IRW));
        step();
        branch_cond = 1'b1;
        #1;
        chk("beq_exec", 32'(strb), 32'(S_PCW));
        chk("beq_pcsel", 32'(pc_sel), 32'd0);
        chk("beq_aluop", 32'(alu_op), 32'd1);
        step();
        branch_cond = 1'b0;
        instr_word  = I_ADDU;
        #1;
        chk("slot_fetch", 32'(strb), 32'(S_IR | S_IRW));
        step();
        #1;
        chk("slot_exec", 32'(strb), 32'(S_PCW | S_RWE));
        chk("slot_pcsel", 32'(pc_sel), 32'd1);

        // MULT: start pulse, then HI/LO write
        step();
        instr_word = I_MULT;
        #1;
        chk("mult_pcsel_clr", 32'(pc_sel), 32'd0);
        chk("mult_fetch", 32'(strb), 32'(S_IR | S_IRW));
        step();
        #1;
        chk("mult_start", 32'(strb), 32'(S_MDS));
        step();
        #1;
        chk("muldiv_w1", 32'(strb), 32'(S_NONE));
        step();
        muldiv_done = 1'b1;
        #1;
        chk("muldiv_w2", 32'(strb), 32'(S_NONE));
        step();
        muldiv_done = 1'b0;
        #1;
`ifdef MULDIV_FIXED_LATENCY_EN
        chk("muldiv_w3", 32'(strb), 32'(S_NONE));
        step();
        #1;
`endif
        chk("muldiv_exit", 32'(strb), 32'(S_HI | S_LO | S_PCW));

        // JR to address 0: halt at the delay-slot PC write
        step();
        instr_word = I_JR;
        #1;
        chk("jr_fetch", 32'(strb), 32'(S_IR | S_IRW));
        step();
        #1;
        chk("jr_exec", 32'(strb), 32'(S_PCW));
        chk("jr_pcsel", 32'(pc_sel), 32'd0);
        step();
        instr_word = I_ADDU;
        #1;
        chk("jr_slot_pcsel", 32'(pc_sel), 32'd3);
        step();
        next_pc_zero = 1'b1;
        #1;
        chk("jr_slot_exec", 32'(strb), 32'(S_PCW | S_RWE));
        chk("jr_slot_pcsel2", 32'(pc_sel), 32'd3);
        chk("jr_slot_active", 32'(active), 32'd1);
        step();
        next_pc_zero = 1'b0;
        #1;
        chk("halt_active", 32'(active), 32'd0);
        chk("halt_strb", 32'(strb), 32'(S_NONE));
        step();
        #1;
        chk("halt_hold", 32'(strb), 32'(S_NONE));

        // Reset while a store is stalled in MEM
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        instr_word = I_SW;
        #1;
        chk("sw_fetch", 32'(strb), 32'(S_IR | S_IRW));
        step();
        mem_waitrequest = 1'b1;
        #1;
        chk("sw_exec", 32'(strb), 32'(S_NONE));
        step();
        #1;
        chk("sw_mem", 32'(strb), 32'(S_DW));
        reset_n = 1'b0;
        #1;
        chk("sw_rst_strb", 32'(strb), 32'(S_NONE));
        chk("sw_rst_active", 32'(active), 32'd0);
        step();
        reset_n = 1'b1;
        mem_waitrequest = 1'b0;
        step();

        // Load stalled for MEM_WAIT_MAX cycles -> bus fault
        instr_word = I_LW;
        #1;
        chk("wl_fetch", 32'(strb), 32'(S_IR | S_IRW));
        step();
        mem_waitrequest = 1'b1;
        step();
        #1;
        chk("wl_mem_first", 32'(strb), 32'(S_DR));
        repeat (254) step();
        #1;
        chk("wl_mem_last", 32'(strb), 32'(S_DR));
        chk("wl_fault_pre", 32'(bus_fault), 32'd0);
        step();
        #1;
        chk("wl_fault", 32'(bus_fault), 32'd1);
        chk("wl_active", 32'(active), 32'd0);
        chk("wl_strb", 32'(strb), 32'(S_NONE));
        reset_n = 1'b0;
        #1;
        chk("wl_fault_clr", 32'(bus_fault), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
